// File: rtl/fp_issue_ctrl.sv
// FP issue controller: accepts decoded FP ops, issues them to FPnew, writes results back
// and accumulates sticky fflags. Optional WAIT watchdog enabled by FP_ISSUE_TIMEOUT_EN.
module fp_issue_ctrl #(
  parameter int unsigned FLEN           = 32,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dec_valid_i,
  input  logic              dec_illegal_i,
  input  logic              dec_ls_i,
  input  logic [3:0]        dec_op_i,
  input  logic              dec_op_mod_i,
  input  logic [2:0]        dec_rm_i,
  input  logic [4:0]        dec_rd_i,
  input  logic              dec_fp_wb_i,
  input  logic              dec_int_wb_i,
  input  logic              dec_move_xs_i,
  input  logic              dec_move_sx_i,
  input  logic [FLEN-1:0]   op_a_i,
  input  logic [FLEN-1:0]   op_b_i,
  input  logic [FLEN-1:0]   op_c_i,
  input  logic [XLEN-1:0]   int_op_i,
  input  logic [2:0]        frm_i,
  input  logic              fflags_clr_i,
  output logic              fpu_in_valid_o,
  input  logic              fpu_in_ready_i,
  output logic [3:0]        fpu_op_o,
  output logic              fpu_op_mod_o,
  output logic [2:0]        fpu_rm_o,
  output logic [3*FLEN-1:0] fpu_operands_o,
  input  logic              fpu_out_valid_i,
  output logic              fpu_out_ready_o,
  input  logic [FLEN-1:0]   fpu_result_i,
  input  logic [4:0]        fpu_status_i,
  output logic              stall_o,
  output logic              illegal_o,
  output logic              fp_wb_en_o,
  output logic [4:0]        fp_wb_addr_o,
  output logic [FLEN-1:0]   fp_wb_data_o,
  output logic              int_wb_en_o,
  output logic [4:0]        int_wb_addr_o,
  output logic [XLEN-1:0]   int_wb_data_o,
  output logic [4:0]        fflags_o,
  output logic              timeout_o
);

  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_I2F = 4'd12;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;

  state_e            state_q, state_d;
  logic              in_valid_q, in_valid_d, out_ready_q, out_ready_d;
  logic [3:0]        op_q, op_d;
  logic              mod_q, mod_d;
  logic [2:0]        rm_q, rm_d;
  logic [4:0]        rd_q, rd_d;
  logic              tgt_fp_q, tgt_fp_d, tgt_int_q, tgt_int_d;
  logic [3*FLEN-1:0] opnd_q, opnd_d;
  logic [4:0]        status_q, status_d, fflags_q, fflags_d;
  logic              illegal_q, illegal_d, timeout_q, timeout_d;
  logic              fp_wb_en_q, fp_wb_en_d, int_wb_en_q, int_wb_en_d;
  logic [FLEN-1:0]   fp_wb_data_q, fp_wb_data_d;
  logic [XLEN-1:0]   int_wb_data_q, int_wb_data_d;
  logic [2:0]        rm_res;
  logic              accept, is_illegal, is_move;

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    rm_res     = (dec_rm_i == 3'b111) ? frm_i : dec_rm_i;
    accept     = (state_q == IDLE) && dec_valid_i && !dec_ls_i;
    is_illegal = dec_illegal_i || (rm_res inside {3'b101, 3'b110, 3'b111});
    is_move    = dec_move_xs_i || dec_move_sx_i;
    stall_o    = (accept && !is_illegal && !is_move) || (state_q == ISSUE) || (state_q == WAIT);

    state_d       = state_q;
    op_d          = op_q;
    mod_d         = mod_q;
    rm_d          = rm_q;
    rd_d          = rd_q;
    tgt_fp_d      = tgt_fp_q;
    tgt_int_d     = tgt_int_q;
    opnd_d        = opnd_q;
    status_d      = status_q;
    fflags_d      = fflags_clr_i ? '0 : fflags_q;
    fp_wb_data_d  = fp_wb_data_q;
    int_wb_data_d = int_wb_data_q;
    illegal_d     = 1'b0;
    timeout_d     = 1'b0;
    fp_wb_en_d    = 1'b0;
    int_wb_en_d   = 1'b0;
`ifdef FP_ISSUE_TIMEOUT_EN
    cnt_d = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_illegal) begin
            illegal_d = 1'b1;
          end else if (dec_move_xs_i) begin
            int_wb_en_d   = 1'b1;
            rd_d          = dec_rd_i;
            int_wb_data_d = XLEN'(op_a_i);
          end else if (dec_move_sx_i) begin
            fp_wb_en_d   = 1'b1;
            rd_d         = dec_rd_i;
            fp_wb_data_d = FLEN'(int_op_i);
          end else begin
            op_d      = dec_op_i;
            mod_d     = dec_op_mod_i;
            rm_d      = rm_res;
            rd_d      = dec_rd_i;
            tgt_fp_d  = dec_fp_wb_i;
            tgt_int_d = dec_int_wb_i;
            if (dec_op_i == OP_ADD)      opnd_d = {op_b_i, op_a_i, {FLEN{1'b0}}};
            else if (dec_op_i == OP_I2F) opnd_d = {{(2*FLEN){1'b0}}, FLEN'(int_op_i)};
            else                         opnd_d = {op_c_i, op_b_i, op_a_i};
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (fpu_in_ready_i) begin
          state_d = WAIT;
`ifdef FP_ISSUE_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        if (fpu_out_valid_i) begin
          state_d  = WB;
          status_d = fpu_status_i;
          if (tgt_fp_q) begin
            fp_wb_en_d   = 1'b1;
            fp_wb_data_d = fpu_result_i;
          end
          if (tgt_int_q) begin
            int_wb_en_d   = 1'b1;
            int_wb_data_d = XLEN'(fpu_result_i);
          end
        end
`ifdef FP_ISSUE_TIMEOUT_EN
        // Count of 0 is the first WAIT cycle, so the limit is hit at TIMEOUT_CYCLES-1.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WB: begin
        fflags_d = fflags_clr_i ? status_q : (fflags_q | status_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_valid_d  = (state_d == ISSUE);
    out_ready_d = (state_d == WAIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      in_valid_q    <= 1'b0;
      out_ready_q   <= 1'b0;
      op_q          <= '0;
      mod_q         <= 1'b0;
      rm_q          <= '0;
      rd_q          <= '0;
      tgt_fp_q      <= 1'b0;
      tgt_int_q     <= 1'b0;
      opnd_q        <= '0;
      status_q      <= '0;
      fflags_q      <= '0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      fp_wb_en_q    <= 1'b0;
      int_wb_en_q   <= 1'b0;
      fp_wb_data_q  <= '0;
      int_wb_data_q <= '0;
`ifdef FP_ISSUE_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      in_valid_q    <= in_valid_d;
      out_ready_q   <= out_ready_d;
      op_q          <= op_d;
      mod_q         <= mod_d;
      rm_q          <= rm_d;
      rd_q          <= rd_d;
      tgt_fp_q      <= tgt_fp_d;
      tgt_int_q     <= tgt_int_d;
      opnd_q        <= opnd_d;
      status_q      <= status_d;
      fflags_q      <= fflags_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      fp_wb_en_q    <= fp_wb_en_d;
      int_wb_en_q   <= int_wb_en_d;
      fp_wb_data_q  <= fp_wb_data_d;
      int_wb_data_q <= int_wb_data_d;
`ifdef FP_ISSUE_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign fpu_in_valid_o  = in_valid_q;
  assign fpu_out_ready_o = out_ready_q;
  assign fpu_op_o        = op_q;
  assign fpu_op_mod_o    = mod_q;
  assign fpu_rm_o        = rm_q;
  assign fpu_operands_o  = opnd_q;
  assign illegal_o       = illegal_q;
  assign fp_wb_en_o      = fp_wb_en_q;
  assign fp_wb_addr_o    = rd_q;
  assign fp_wb_data_o    = fp_wb_data_q;
  assign int_wb_en_o     = int_wb_en_q;
  assign int_wb_addr_o   = rd_q;
  assign int_wb_data_o   = int_wb_data_q;
  assign fflags_o        = fflags_q;
`ifdef FP_ISSUE_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
